// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port synchronous memory.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module mem_arbiter #(
   parameter int WIDTH_ADDR = 5,
   parameter int WIDTH_DATA = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_0,
   input  logic                  we_0,
   input  logic [WIDTH_ADDR-1:0] addr_0,
   input  logic [WIDTH_DATA-1:0] wdata_0,
   output logic                  ack_0,
   output logic [WIDTH_DATA-1:0] rdata_0,
   input  logic                  req_1,
   input  logic                  we_1,
   input  logic [WIDTH_ADDR-1:0] addr_1,
   input  logic [WIDTH_DATA-1:0] wdata_1,
   output logic                  ack_1,
   output logic [WIDTH_DATA-1:0] rdata_1,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [WIDTH_ADDR-1:0] mem_addr,
   output logic [WIDTH_DATA-1:0] mem_data_in,
   input  logic [WIDTH_DATA-1:0] mem_data_out,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

   state_t                state;
   state_t                next_state;
   logic                  sel;
   logic                  grant;
   logic                  start;
   logic                  lat_we;
   logic [WIDTH_ADDR-1:0] lat_addr;
   logic [WIDTH_DATA-1:0] lat_wdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
   logic                  last;
`endif

   assign start = req_0 | req_1;

   // Winner selection; only meaningful while start is high.
   always_comb begin
      grant = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant = ~req_0;
`else
      if (req_0 && req_1)
         grant = ~last;
      else
         grant = ~req_0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ISSUE;
         ISSUE:   next_state = lat_we ? RESP : RDWAIT;
         RDWAIT:  next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request latch, read-data capture and round-robin history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel       <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata_0   <= '0;
         rdata_1   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last      <= 1'b1;
`endif
      end else begin
         if (state == IDLE && start) begin
            sel       <= grant;
            lat_we    <= grant ? we_1    : we_0;
            lat_addr  <= grant ? addr_1  : addr_0;
            lat_wdata <= grant ? wdata_1 : wdata_0;
         end
         if (state == RDWAIT) begin
            if (sel)
               rdata_1 <= mem_data_out;
            else
               rdata_0 <= mem_data_out;
         end
`ifndef MEM_ARB_FIXED_PRIO_EN
         if (next_state == RESP)
            last <= sel;
`endif
      end
   end

   // Strobes and acks decode purely from registered state.
   assign mem_write   = (state == ISSUE) &&  lat_we;
   assign mem_read    = (state == ISSUE) && !lat_we;
   assign mem_addr    = lat_addr;
   assign mem_data_in = lat_wdata;
   assign ack_0       = (state == RESP) && !sel;
   assign ack_1       = (state == RESP) &&  sel;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 32x8 memory model.
// Honours MEM_ARB_FIXED_PRIO_EN for the expected contention grant order.
module tb_mem_arbiter;

   logic       clk;
   logic       rst;
   logic       req_0, we_0, ack_0;
   logic [4:0] addr_0;
   logic [7:0] wdata_0, rdata_0;
   logic       req_1, we_1, ack_1;
   logic [4:0] addr_1;
   logic [7:0] wdata_1, rdata_1;
   logic       mem_read, mem_write, busy;
   logic [4:0] mem_addr;
   logic [7:0] mem_data_in, mem_data_out;

   logic [7:0] mem_model [32];

   int compared   = 0;
   int mismatched = 0;

   mem_arbiter #(.WIDTH_ADDR(5), .WIDTH_DATA(8)) dut (
      .clk(clk), .rst(rst),
      .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
      .ack_0(ack_0), .rdata_0(rdata_0),
      .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .ack_1(ack_1), .rdata_1(rdata_1),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous memory: registered read data, 0 when not reading.
   always_ff @(posedge clk) begin
      if (mem_write)
         mem_model[mem_addr] <= mem_data_in;
      mem_data_out <= mem_read ? mem_model[mem_addr] : 8'h00;
   end

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input int id, input logic req, input logic we,
                                 input logic [4:0] addr, input logic [7:0] wdata);
      if (id == 0) begin
         req_0 = req; we_0 = we; addr_0 = addr; wdata_0 = wdata;
      end else begin
         req_1 = req; we_1 = we; addr_1 = addr; wdata_1 = wdata;
      end
   endtask

   // One full transaction, checked cycle by cycle; called just after a negedge.
   task automatic run_txn(input int id, input logic we, input logic [4:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_r0,
                          input logic [7:0] exp_r1);
      logic [1:0] exp_ack;
      exp_ack = (id == 0) ? 2'b01 : 2'b10;
      apply_stimulus(id, 1'b1, we, addr, wdata);
      @(negedge clk);
      check_output("issue_strobe", {mem_write, mem_read}, we ? 2'b10 : 2'b01);
      check_output("issue_addr", mem_addr, addr);
      check_output("issue_wdata", mem_data_in, wdata);
      check_output("issue_ack_busy", {ack_1, ack_0, busy}, 3'b001);
      apply_stimulus(id, 1'b1, ~we, ~addr, ~wdata);
      if (!we) begin
         @(negedge clk);
         check_output("rdwait_outs", {mem_write, mem_read, ack_1, ack_0, busy}, 5'b00001);
      end
      @(negedge clk);
      check_output("resp_ack", {ack_1, ack_0}, exp_ack);
      check_output("resp_strobe_busy", {mem_write, mem_read, busy}, 3'b001);
      check_output("resp_rdata_0", rdata_0, exp_r0);
      check_output("resp_rdata_1", rdata_1, exp_r1);
      apply_stimulus(id, 1'b0, 1'b0, 5'd0, 8'd0);
      @(negedge clk);
      check_output("idle_ack_busy", {ack_1, ack_0, busy}, 3'b000);
      check_output("idle_addr_hold", mem_addr, addr);
   endtask

   initial begin
      logic [1:0] exp_grant;
      logic [1:0] got_grant;

      // Reset with random requester activity: every output must read 0.
      rst = 1'b1;
      req_0 = 1'($urandom); we_0 = 1'($urandom); addr_0 = 5'($urandom); wdata_0 = 8'($urandom);
      req_1 = 1'($urandom); we_1 = 1'($urandom); addr_1 = 5'($urandom); wdata_1 = 8'($urandom);
      repeat (2) @(negedge clk);
      check_output("reset_outputs",
                   {ack_0, rdata_0, ack_1, rdata_1, mem_read, mem_write, mem_addr, mem_data_in, busy}, 64'd0);
      apply_stimulus(0, 1'b0, 1'b0, 5'd0, 8'd0);
      apply_stimulus(1, 1'b0, 1'b0, 5'd0, 8'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("idle_quiet", {busy, mem_read, mem_write, ack_0, ack_1}, 5'd0);
      end

      $display("[TB] write A5 to 3, read it back");
      run_txn(0, 1'b1, 5'd3, 8'hA5, 8'h00, 8'h00);
      run_txn(0, 1'b0, 5'd3, 8'h00, 8'hA5, 8'h00);

      $display("[TB] boundary address 31");
      run_txn(1, 1'b1, 5'd31, 8'hFF, 8'hA5, 8'h00);
      run_txn(0, 1'b0, 5'd31, 8'h00, 8'hFF, 8'h00);

      $display("[TB] reset during RDWAIT of requester 1");
      apply_stimulus(1, 1'b1, 1'b0, 5'd31, 8'h00);
      @(negedge clk);
      check_output("pre_reset_issue", {mem_read, mem_write, busy}, 3'b101);
      @(negedge clk);
      check_output("pre_reset_rdwait", {mem_read, mem_write, busy, ack_1}, 4'b0010);
      rst = 1'b1;
      #1;
      check_output("async_reset_outs",
                   {ack_0, rdata_0, ack_1, rdata_1, mem_read, mem_write, mem_addr, mem_data_in, busy}, 64'd0);
      apply_stimulus(1, 1'b0, 1'b0, 5'd0, 8'd0);
      @(negedge clk);
      check_output("held_reset_outs", {ack_1, rdata_1, busy, mem_read}, 11'd0);
      rst = 1'b0;
      @(negedge clk);
      check_output("post_reset_idle", {ack_1, ack_0, busy}, 3'b000);
      run_txn(1, 1'b0, 5'd31, 8'h00, 8'h00, 8'hFF);

      $display("[TB] contention from reset");
      rst = 1'b1;
      apply_stimulus(0, 1'b1, 1'b1, 5'd5, 8'h11);
      apply_stimulus(1, 1'b1, 1'b1, 5'd6, 8'h22);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         exp_grant = 2'b01;
`else
         exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
         got_grant = 2'b00;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            got_grant = {ack_1, ack_0};
            if (got_grant != 2'b00) break;
         end
         check_output("grant_order", got_grant, exp_grant);
         if (got_grant[0]) req_0 = 1'b0;
         if (got_grant[1]) req_1 = 1'b0;
         @(negedge clk);
         req_0 = 1'b1;
         req_1 = 1'b1;
      end
      apply_stimulus(0, 1'b0, 1'b0, 5'd0, 8'd0);
      apply_stimulus(1, 1'b0, 1'b0, 5'd0, 8'd0);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
